// File: rtl/arbiter_rr.sv
// Round-robin arbiter with request lock: a holder keeps its grant while it requests.
// Optional hold limit (ARBITER_RR_TIMEOUT_EN) forces handover after MAX_HOLD cycles.
//
// state | meaning
// IDLE  | no requester granted
// GRANT | one requester holds the grant
module arbiter_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                                 clk,
  input  logic                                 res,
  input  logic [N-1:0]                         req,
  output logic [N-1:0]                         grant,
  output logic                                 grant_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_id
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("arbiter_rr: N out of range");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("arbiter_rr: MAX_HOLD out of range");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic            holder_req;
  logic            release_grant;

  // Search starts just after the last holder, so the last holder is checked last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = ptr;
    for (int i = 0; i < N; i++) begin
      idx = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign holder_req = |(req & grant);

`ifdef ARBITER_RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  logic [7:0] hold_cnt;
  logic       others_req;
  assign others_req    = |(req & ~grant);
  assign release_grant = !holder_req || ((hold_cnt == HOLD_MAX) && others_req);
`else
  assign release_grant = !holder_req;
`endif

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= IW'(N - 1);
`ifdef ARBITER_RR_TIMEOUT_EN
      hold_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= GRANT;
            grant       <= {{(N-1){1'b0}}, 1'b1} << pick;
            grant_valid <= 1'b1;
            grant_id    <= pick;
            ptr         <= pick;
`ifdef ARBITER_RR_TIMEOUT_EN
            hold_cnt    <= 8'd1;
`endif
          end
        end
        GRANT: begin
          if (!release_grant) begin
`ifdef ARBITER_RR_TIMEOUT_EN
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
`endif
          end else if (found) begin
            grant       <= {{(N-1){1'b0}}, 1'b1} << pick;
            grant_valid <= 1'b1;
            grant_id    <= pick;
            ptr         <= pick;
`ifdef ARBITER_RR_TIMEOUT_EN
            hold_cnt    <= 8'd1;
`endif
          end else begin
            // ptr keeps the last holder so it gets lowest priority next time
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef ARBITER_RR_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr with N=3, MAX_HOLD=4; expectations follow
// ARBITER_RR_TIMEOUT_EN when the bench is built with that macro.
module tb_arbiter_rr;
  localparam int N  = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          res;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  int errors = 0;
  int checks = 0;

  arbiter_rr #(.N(N), .MAX_HOLD(4)) dut (
    .clk(clk), .res(res), .req(req),
    .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== 6'b000_0_00) begin
        errors++;
        $display("FAIL reset cyc%0d: grant=%b valid=%b id=%0d, expected 000/0/0",
                 i, grant, grant_valid, grant_id);
      end
    end
    res = 1'b0;
    step();
    checks++;
    if ({grant, grant_valid, grant_id} !== {3'b001, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_release: grant=%b valid=%b id=%0d, expected 001/1/0",
               grant, grant_valid, grant_id);
    end
  endtask

  task automatic test_lock_rotation();
    logic [2:0] rv[5] = '{3'b111, 3'b111, 3'b110, 3'b100, 3'b001};
    logic [2:0] eg[5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] ei[5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 5; i++) begin
      req = rv[i];
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== {eg[i], |eg[i], ei[i]}) begin
        errors++;
        $display("FAIL rotation step%0d: grant=%b valid=%b id=%0d, expected %b/%b/%0d",
                 i, grant, grant_valid, grant_id, eg[i], |eg[i], ei[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] rv[3] = '{3'b100, 3'b101, 3'b001};
    logic [2:0] eg[3] = '{3'b100, 3'b100, 3'b001};
    logic [1:0] ei[3] = '{2'd2, 2'd2, 2'd0};
    for (int i = 0; i < 3; i++) begin
      req = rv[i];
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== {eg[i], |eg[i], ei[i]}) begin
        errors++;
        $display("FAIL wrap step%0d: grant=%b valid=%b id=%0d, expected %b/%b/%0d",
                 i, grant, grant_valid, grant_id, eg[i], |eg[i], ei[i]);
      end
    end
  endtask

  task automatic test_idle();
    logic [2:0] rv[4] = '{3'b010, 3'b000, 3'b000, 3'b011};
    logic [2:0] eg[4] = '{3'b010, 3'b000, 3'b000, 3'b001};
    logic [1:0] ei[4] = '{2'd1, 2'd0, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      req = rv[i];
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== {eg[i], |eg[i], ei[i]}) begin
        errors++;
        $display("FAIL idle step%0d: grant=%b valid=%b id=%0d, expected %b/%b/%0d",
                 i, grant, grant_valid, grant_id, eg[i], |eg[i], ei[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic       rs[3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] rv[3] = '{3'b110, 3'b111, 3'b111};
    logic [2:0] eg[3] = '{3'b010, 3'b000, 3'b001};
    logic [1:0] ei[3] = '{2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      res = rs[i];
      req = rv[i];
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== {eg[i], |eg[i], ei[i]}) begin
        errors++;
        $display("FAIL reset_mid step%0d: grant=%b valid=%b id=%0d, expected %b/%b/%0d",
                 i, grant, grant_valid, grant_id, eg[i], |eg[i], ei[i]);
      end
    end
    res = 1'b0;
  endtask

  task automatic test_timeout();
    logic [2:0] exp_g;
    res = 1'b1;
    step();
    res = 1'b0;
    req = 3'b011;
    for (int k = 0; k < 12; k++) begin
      step();
`ifdef ARBITER_RR_TIMEOUT_EN
      exp_g = (((k / 4) % 2) == 0) ? 3'b001 : 3'b010;
`else
      exp_g = 3'b001;
`endif
      checks++;
      if ({grant, grant_valid} !== {exp_g, 1'b1} ||
          grant_id !== ((exp_g == 3'b010) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL timeout_alt cyc%0d: grant=%b valid=%b id=%0d, expected %b/1",
                 k, grant, grant_valid, grant_id, exp_g);
      end
    end
    req = 3'b001;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({grant, grant_valid, grant_id} !== {3'b001, 1'b1, 2'd0}) begin
        errors++;
        $display("FAIL timeout_alone cyc%0d: grant=%b valid=%b id=%0d, expected 001/1/0",
                 k, grant, grant_valid, grant_id);
      end
    end
  endtask

  initial begin
    res = 1'b1;
    req = '0;
    test_reset();
    test_lock_rotation();
    test_wrap();
    test_idle();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters (2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles per holder (1..255), used only with the Configuration macro.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port res  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req  input  N  request vector, bit i = requester i.
REQ-006 The block SHALL have port grant  output  N  one-hot grant vector, registered.
REQ-007 The block SHALL have port grant_valid  output  1  high when any grant bit is set, registered.
REQ-008 The block SHALL have port grant_id  output  clog2(N)  index of the granted requester, 0 when grant_valid low, registered.

Function
REQ-009 grant SHALL be one-hot or all-zero at every clock edge; grant_valid SHALL equal OR of grant; grant_id SHALL encode grant.
REQ-010 Latency: a request sampled at edge k with no current holder SHALL be granted with outputs valid after edge k (one cycle).
REQ-011 States: IDLE (no grant) and GRANT (one holder); IDLE->GRANT when any req sampled high; GRANT->IDLE when holder req low and no other req high; GRANT->GRANT(new holder) when holder req low and another req high.
REQ-012 Lock: holder SHALL keep grant on every edge where its req bit is sampled high (subject to REQ-019).
REQ-013 Selection SHALL be round-robin: search starts at index ptr+1, wraps N-1->0, first set req bit wins; ptr SHALL update to the new holder index on every new grant.
REQ-014 Handover with holder release and other pending requests on the same edge SHALL occur with no idle cycle between grants.
REQ-015 A requester SHALL NOT be regranted while any other requester is pending at the edge its grant is released.
REQ-016 If only the releasing holder's bit is low and no others set, grant SHALL go all-zero on that edge; ptr SHALL keep the last holder.
REQ-017 Requests dropped before being granted SHALL be ignored; no request memory exists beyond the req vector.

Reset
REQ-018 With res sampled high: grant=0, grant_valid=0, grant_id=0, ptr=N-1 (requester 0 first priority), hold counter=0, state IDLE; res SHALL override all requests on that edge, including mid-grant.

Configuration
REQ-019 Macro ARBITER_RR_TIMEOUT_EN defined: a hold counter SHALL count holder cycles (1 on grant cycle); when it equals MAX_HOLD and any other req bit is high, the next edge SHALL hand grant per REQ-013 even if holder req is high; with no other request the holder SHALL keep grant and the counter SHALL saturate at MAX_HOLD; counter resets to 1 on every new grant.
REQ-020 Macro not defined: no hold counter SHALL exist; grant held indefinitely per REQ-012; MAX_HOLD ignored.

Verification (N=3, MAX_HOLD=4)
REQ-021 res=1 for 10 cycles, req=3'b111 -> grant=000, grant_valid=0 throughout; release res with req=111 -> grant=001 one cycle later, grant_id=0.
REQ-022 req=111, drop req0 while held -> next edge grant=010 with no zero cycle; drop req1 -> grant=100; drop req2, assert req0 -> grant=001.
REQ-023 Holder 2 (ptr=2), req=101 on release of req2 -> grant=001 (wrap), not 100 again.
REQ-024 req=010 only, then req=000 -> grant=010 then 000, grant_valid 1 then 0; reassert req=011 -> grant=001 next (ptr=1 wraps to 2,0).
REQ-025 res asserted mid-grant with req=111 -> grant=000 next edge; after release grant=001.
REQ-026 ARBITER_RR_TIMEOUT_EN defined, req=011 held constant -> grant alternates 001 for 4 cycles, 010 for 4 cycles; req=001 only -> grant=001 stays beyond 4 cycles; without macro, req=011 -> grant=001 indefinitely.
